// File: rtl/regfile_arb_pkg.sv
// Shared definitions for the register-file port arbiter.
//   state_t    : arbiter FSM states
//   REG0_INDEX : hard-wired zero register; debug writes to it are dropped
package regfile_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DBG_RD = 3'd1,
    DBG_WR = 3'd2,
    DUMP   = 3'd3,
    ACK    = 3'd4
  } state_t;

  localparam logic [4:0] REG0_INDEX = 5'd0;

endpackage

// File: rtl/regfile_dump_seq.sv
// Dump sequencer: holds the dump-pending flag and the index of the next
// register to dump. The index is only advanced in cycles where the arbiter
// actually owns read port B for the dump, so a pause keeps the index and the
// dump resumes where it stopped.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : dump request pulse (ignored while a dump is pending)
//   advance   : arbiter spent this cycle dumping register idx
//   idx       : register index to dump next / being dumped
//   busy      : dump pending or in progress
//   last      : this advance cycle dumps the final register
module regfile_dump_seq #(
  parameter int REGNUM = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       advance,
  output logic [4:0] idx,
  output logic       busy,
  output logic       last
);

  localparam logic [4:0] LAST_IDX = 5'(REGNUM - 1);

  logic [4:0] idx_reg;
  logic       pending_reg;

  assign last = advance && (idx_reg == LAST_IDX);
  assign idx  = idx_reg;
  assign busy = pending_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg     <= 5'd0;
      pending_reg <= 1'b0;
    end else if (advance) begin
      if (idx_reg == LAST_IDX) begin
        idx_reg     <= 5'd0;
        pending_reg <= 1'b0;
      end else begin
        idx_reg <= idx_reg + 5'd1;
      end
    end else if (start && !pending_reg) begin
      idx_reg     <= 5'd0;
      pending_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register-file write port and read port B between the CPU and a
// debug host. Debug reads/writes and register dumps steal the ports for one
// cycle at a time by stalling the CPU; a starvation guard hands the CPU one
// free slot after STARVE_MAX consecutive stalled cycles.
// Ports:
//   CLK, RST                        : clock, asynchronous active-high reset
//   cpu_we/cpu_rw/cpu_wdata/cpu_rb  : CPU write port and read-B address
//   cpu_busB, cpu_stall             : read-B data back to CPU, CPU hold
//   rf_we/rf_rw/rf_wdata/rf_rb      : register file write port and read-B addr
//   rf_busB                         : register file read-B data (combinational)
//   dbg_*                           : debug host request/ack handshake
//   dump_*                          : full register dump control and stream
module regfile_port_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int REGNUM     = 8,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cpu_we,
  input  logic [4:0]    cpu_rw,
  input  logic [DW-1:0] cpu_wdata,
  input  logic [4:0]    cpu_rb,
  output logic [DW-1:0] cpu_busB,
  output logic          cpu_stall,
  output logic          rf_we,
  output logic [4:0]    rf_rw,
  output logic [DW-1:0] rf_wdata,
  output logic [4:0]    rf_rb,
  input  logic [DW-1:0] rf_busB,
  input  logic          dbg_req,
  input  logic          dbg_wr,
  input  logic [4:0]    dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  input  logic          dump_start,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic [4:0]    dump_idx,
  output logic [DW-1:0] dump_data
);

  localparam int         CW       = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX);
  localparam logic [5:0] REGNUM_W = 6'(REGNUM);

  state_t          state_reg, state_next;
  logic [CW-1:0]   starve_cnt_reg;
  logic [DW-1:0]   dbg_rdata_reg;
  logic            force_slot;
  logic            dump_last;
  logic            addr_in_range;

  assign addr_in_range = ({1'b0, dbg_addr} < REGNUM_W);

  // Last stalled cycle allowed in a row; the following cycle goes to the CPU.
  assign force_slot = cpu_stall && (starve_cnt_reg == CW'(STARVE_MAX - 1));

  regfile_dump_seq #(.REGNUM(REGNUM)) u_dump_seq (
    .clk     (CLK),
    .rst     (RST),
    .start   (dump_start),
    .advance (state_reg == DUMP),
    .idx     (dump_idx),
    .busy    (dump_busy),
    .last    (dump_last)
  );

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; debug requests win over dump start/resume.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (dbg_req)                      state_next = dbg_wr ? DBG_WR : DBG_RD;
        else if (dump_start || dump_busy) state_next = DUMP;
      end
      DBG_RD, DBG_WR: state_next = ACK;
      // Pausing to IDLE gives the CPU its slot; pending dump re-enters next.
      DUMP:    if (dump_last || force_slot) state_next = IDLE;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode and port mux
  always_comb begin
    rf_we    = 1'b0;
    rf_rw    = 5'd0;
    rf_wdata = '0;
    rf_rb    = 5'd0;
    if (!RST) begin
      case (state_reg)
        IDLE, ACK: begin
          rf_we    = cpu_we;
          rf_rw    = cpu_rw;
          rf_wdata = cpu_wdata;
          rf_rb    = cpu_rb;
        end
        DBG_RD: rf_rb = dbg_addr;
        DBG_WR: begin
          rf_we    = addr_in_range && (dbg_addr != REG0_INDEX);
          rf_rw    = dbg_addr;
          rf_wdata = dbg_wdata;
          rf_rb    = dbg_addr;
        end
        DUMP:    rf_rb = dump_idx;
        default: ;
      endcase
    end
  end

  assign cpu_stall  = (state_reg == DBG_RD) || (state_reg == DBG_WR) || (state_reg == DUMP);
  assign dbg_ack    = (state_reg == ACK);
  assign dump_valid = (state_reg == DUMP);
  assign dump_data  = dump_valid ? rf_busB : '0;
  assign cpu_busB   = rf_busB;
  assign dbg_rdata  = dbg_rdata_reg;

  // Read data is captured at the edge closing DBG_RD and held until the next read.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                      dbg_rdata_reg <= '0;
    else if (state_reg == DBG_RD) dbg_rdata_reg <= addr_in_range ? rf_busB : '0;
  end

  // Consecutive-stall counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                            starve_cnt_reg <= '0;
    else if (!cpu_stall || force_slot)  starve_cnt_reg <= '0;
    else                                starve_cnt_reg <= starve_cnt_reg + CW'(1);
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
module tb_regfile_port_arbiter;
  localparam int REGNUM     = 8;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          cpu_we;
  logic [4:0]    cpu_rw;
  logic [DW-1:0] cpu_wdata;
  logic [4:0]    cpu_rb;
  logic [DW-1:0] cpu_busB;
  logic          cpu_stall;
  logic          rf_we;
  logic [4:0]    rf_rw;
  logic [DW-1:0] rf_wdata;
  logic [4:0]    rf_rb;
  logic [DW-1:0] rf_busB;
  logic          dbg_req;
  logic          dbg_wr;
  logic [4:0]    dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic          dump_start;
  logic          dump_busy;
  logic          dump_valid;
  logic [4:0]    dump_idx;
  logic [DW-1:0] dump_data;

  always #5 CLK = ~CLK;

  regfile_port_arbiter #(.REGNUM(REGNUM), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .CLK(CLK), .RST(RST),
    .cpu_we(cpu_we), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata), .cpu_rb(cpu_rb),
    .cpu_busB(cpu_busB), .cpu_stall(cpu_stall),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_wdata(rf_wdata), .rf_rb(rf_rb), .rf_busB(rf_busB),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_idx(dump_idx), .dump_data(dump_data)
  );

  // Register file environment: reg 0 reads zero, only REGNUM registers exist.
  logic [DW-1:0] rf_mem [0:31];
  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
    end else if (rf_we && rf_rw != 5'd0 && int'(rf_rw) < REGNUM) begin
      rf_mem[rf_rw] <= rf_wdata;
    end
  end
  assign rf_busB = rf_mem[rf_rb];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_we = 0; cpu_rw = 0; cpu_wdata = 0; cpu_rb = 0;
    dbg_req = 0; dbg_wr = 0; dbg_addr = 0; dbg_wdata = 0;
    dump_start = 0;
  endtask

  typedef struct {
    logic          req;
    logic          wr;
    logic [4:0]    addr;
    logic [DW-1:0] wdata;
    logic          cwe;
    logic [4:0]    crw;
    logic [DW-1:0] cwd;
    logic          e_stall;
    logic          e_ack;
    logic          e_we;
    logic [4:0]    e_rw;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic req, input logic wr, input logic [4:0] addr,
                     input logic [DW-1:0] wdata, input logic cwe, input logic [4:0] crw,
                     input logic [DW-1:0] cwd, input logic e_stall, input logic e_ack,
                     input logic e_we, input logic [4:0] e_rw, input logic [DW-1:0] e_rdata);
    vec_t r;
    r.req = req; r.wr = wr; r.addr = addr; r.wdata = wdata;
    r.cwe = cwe; r.crw = crw; r.cwd = cwd;
    r.e_stall = e_stall; r.e_ack = e_ack; r.e_we = e_we; r.e_rw = e_rw; r.e_rdata = e_rdata;
    vecs.push_back(r);
  endtask

  initial begin
    logic found;
    idle_inputs();

    //   req wr addr wdata         cwe rw cwd      stall ack we rw rdata
    add(0, 0, 0, 0,             0, 0, 0,        0, 0, 0, 0, 0);
    add(1, 1, 3, 32'hDEADBEEF,  0, 0, 0,        0, 0, 0, 0, 0);
    add(1, 1, 3, 32'hDEADBEEF,  1, 2, 32'h11,   1, 0, 1, 3, 0);  // DBG_WR, CPU write blocked
    add(1, 1, 3, 32'hDEADBEEF,  1, 2, 32'h22,   0, 1, 1, 2, 0);  // ACK, CPU write passes
    add(0, 0, 0, 0,             0, 0, 0,        0, 0, 0, 0, 0);
    add(1, 0, 3, 0,             0, 0, 0,        0, 0, 0, 0, 0);
    add(1, 0, 3, 0,             0, 0, 0,        1, 0, 0, 0, 0);
    add(1, 0, 3, 0,             0, 0, 0,        0, 1, 0, 0, 32'hDEADBEEF);
    add(0, 0, 0, 0,             0, 0, 0,        0, 0, 0, 0, 32'hDEADBEEF);
    add(1, 0, 2, 0,             0, 0, 0,        0, 0, 0, 0, 32'hDEADBEEF);
    add(1, 0, 2, 0,             0, 0, 0,        1, 0, 0, 0, 32'hDEADBEEF);
    add(1, 0, 2, 0,             0, 0, 0,        0, 1, 0, 0, 32'h22);
    add(0, 0, 0, 0,             0, 0, 0,        0, 0, 0, 0, 32'h22);
    add(1, 1, 0, 32'h5,         0, 0, 0,        0, 0, 0, 0, 32'h22);
    add(1, 1, 0, 32'h5,         0, 0, 0,        1, 0, 0, 0, 32'h22);  // reg 0 write dropped
    add(1, 1, 0, 32'h5,         0, 0, 0,        0, 1, 0, 0, 32'h22);
    add(0, 0, 0, 0,             0, 0, 0,        0, 0, 0, 0, 32'h22);
    add(1, 1, 9, 32'h99,        0, 0, 0,        0, 0, 0, 0, 32'h22);
    add(1, 1, 9, 32'h99,        0, 0, 0,        1, 0, 0, 0, 32'h22);  // out of range dropped
    add(1, 1, 9, 32'h99,        0, 0, 0,        0, 1, 0, 0, 32'h22);
    add(0, 0, 0, 0,             0, 0, 0,        0, 0, 0, 0, 32'h22);
    add(1, 0, 9, 0,             0, 0, 0,        0, 0, 0, 0, 32'h22);
    add(1, 0, 9, 0,             0, 0, 0,        1, 0, 0, 0, 32'h22);
    add(1, 0, 9, 0,             0, 0, 0,        0, 1, 0, 0, 32'h0);   // out of range reads 0
    add(0, 0, 0, 0,             0, 0, 0,        0, 0, 0, 0, 32'h0);
    add(0, 0, 0, 0,             1, 4, 32'h44,   0, 0, 1, 4, 32'h0);

    // Reset state
    #2 RST = 1'b1;
    #1;
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_ack", 32'(dbg_ack), 0);
    chk("rst_rdata", dbg_rdata, 0);
    chk("rst_busy", 32'(dump_busy), 0);
    chk("rst_valid", 32'(dump_valid), 0);
    chk("rst_idx", 32'(dump_idx), 0);
    chk("rst_we", 32'(rf_we), 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Table-driven debug access vectors, one row per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      dbg_req = vecs[i].req; dbg_wr = vecs[i].wr; dbg_addr = vecs[i].addr;
      dbg_wdata = vecs[i].wdata; cpu_we = vecs[i].cwe; cpu_rw = vecs[i].crw;
      cpu_wdata = vecs[i].cwd;
      @(negedge CLK);
      $display("vec %0d: req=%0b wr=%0b addr=%0d stall=%0b ack=%0b we=%0b rw=%0d rdata=%0h",
               i, dbg_req, dbg_wr, dbg_addr, cpu_stall, dbg_ack, rf_we, rf_rw, dbg_rdata);
      chk($sformatf("vec%0d_stall", i), 32'(cpu_stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_ack", i), 32'(dbg_ack), 32'(vecs[i].e_ack));
      chk($sformatf("vec%0d_we", i), 32'(rf_we), 32'(vecs[i].e_we));
      if (vecs[i].e_we) chk($sformatf("vec%0d_rw", i), 32'(rf_rw), 32'(vecs[i].e_rw));
      chk($sformatf("vec%0d_rdata", i), dbg_rdata, vecs[i].e_rdata);
      step();
    end
    idle_inputs();

    // Preload registers 1..7 with i*0x11 through the CPU path
    for (int i = 1; i < REGNUM; i++) begin
      cpu_we = 1; cpu_rw = 5'(i); cpu_wdata = DW'(i * 32'h11);
      @(negedge CLK);
      chk($sformatf("preload%0d_we", i), 32'(rf_we), 1);
      step();
    end
    idle_inputs();

    // Full dump with one forced CPU slot after four stalled cycles
    dump_start = 1;
    @(negedge CLK);
    chk("dump_start_valid", 32'(dump_valid), 0);
    step();
    dump_start = 0;
    for (int k = 0; k < 10; k++) begin
      logic       ev;
      logic [4:0] ei;
      ev = (k < 4) || (k >= 5 && k <= 8);
      ei = (k < 4) ? 5'(k) : 5'(k - 1);
      @(negedge CLK);
      $display("dump cyc %0d: valid=%0b idx=%0d data=%0h stall=%0b busy=%0b",
               k, dump_valid, dump_idx, dump_data, cpu_stall, dump_busy);
      chk($sformatf("dump%0d_valid", k), 32'(dump_valid), 32'(ev));
      chk($sformatf("dump%0d_stall", k), 32'(cpu_stall), 32'(ev));
      chk($sformatf("dump%0d_busy", k), 32'(dump_busy), (k <= 8) ? 1 : 0);
      if (ev) begin
        chk($sformatf("dump%0d_idx", k), 32'(dump_idx), 32'(ei));
        chk($sformatf("dump%0d_data", k), dump_data, 32'(ei) * 32'h11);
      end
      step();
    end

    // Debug read and dump start in the same cycle: read first, then dump
    dbg_req = 1; dbg_wr = 0; dbg_addr = 5; dump_start = 1;
    @(negedge CLK);
    chk("sim_idle_stall", 32'(cpu_stall), 0);
    step();
    dump_start = 0;
    @(negedge CLK);
    $display("sim rd: stall=%0b busy=%0b valid=%0b", cpu_stall, dump_busy, dump_valid);
    chk("sim_rd_stall", 32'(cpu_stall), 1);
    chk("sim_rd_busy", 32'(dump_busy), 1);
    chk("sim_rd_valid", 32'(dump_valid), 0);
    step();
    @(negedge CLK);
    $display("sim ack: ack=%0b rdata=%0h busy=%0b", dbg_ack, dbg_rdata, dump_busy);
    chk("sim_ack", 32'(dbg_ack), 1);
    chk("sim_rdata", dbg_rdata, 32'h55);
    chk("sim_ack_valid", 32'(dump_valid), 0);
    step();
    dbg_req = 0;
    @(negedge CLK);
    chk("sim_gap_valid", 32'(dump_valid), 0);
    chk("sim_gap_stall", 32'(cpu_stall), 0);
    step();
    @(negedge CLK);
    $display("sim dump: valid=%0b idx=%0d data=%0h", dump_valid, dump_idx, dump_data);
    chk("sim_dump_valid", 32'(dump_valid), 1);
    chk("sim_dump_idx", 32'(dump_idx), 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      @(negedge CLK);
      if (!dump_busy) found = 1;
    end
    chk("sim_dump_done", 32'(found), 1);
    step();

    // Asynchronous reset in the middle of a dump
    dump_start = 1;
    step();
    dump_start = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge CLK);
      if (dump_valid && dump_idx == 5'd5) found = 1;
      else step();
    end
    chk("mid_found_idx5", 32'(found), 1);
    #2 RST = 1'b1;
    #1;
    $display("mid rst: stall=%0b valid=%0b busy=%0b idx=%0d rdata=%0h",
             cpu_stall, dump_valid, dump_busy, dump_idx, dbg_rdata);
    chk("mid_rst_stall", 32'(cpu_stall), 0);
    chk("mid_rst_valid", 32'(dump_valid), 0);
    chk("mid_rst_busy", 32'(dump_busy), 0);
    chk("mid_rst_idx", 32'(dump_idx), 0);
    chk("mid_rst_rdata", dbg_rdata, 0);
    chk("mid_rst_data", dump_data, 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      chk($sformatf("post_rst%0d_valid", k), 32'(dump_valid), 0);
      chk($sformatf("post_rst%0d_busy", k), 32'(dump_busy), 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
- Shares the register file's write port and read port B between the single-cycle CPU and a debug/hardware-test host.
- Debug reads, debug writes and full-register dumps each steal the ports for one cycle by stalling the CPU.
- Sits between the CPU datapath and the register file in the hardware-test build; the CPU sees an unchanged busB path when idle.

Parameters:
- REGNUM, 8, number of implemented registers; dump range is 0..REGNUM-1.
- DW, 32, data width.
- STARVE_MAX, 4, maximum consecutive stalled cycles before one CPU slot is forced; minimum 1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- cpu_we  in  1  CPU writeback enable (RegWr).
- cpu_rw  in  5  CPU write address.
- cpu_wdata  in  DW  CPU write data.
- cpu_rb  in  5  CPU read-port-B address.
- cpu_busB  out  DW  busB returned to CPU (rf_busB passthrough).
- cpu_stall  out  1  CPU must hold PC and state this cycle.
- rf_we / rf_rw / rf_wdata  out  1/5/DW  register file write port (RegWr/rw/busW).
- rf_rb  out  5  register file read address B.
- rf_busB  in  DW  register file busB, combinational.
- dbg_req  in  1  debug request; held until dbg_ack.
- dbg_wr  in  1  1 = write, 0 = read; stable while dbg_req is high.
- dbg_addr  in  5  debug register address.
- dbg_wdata  in  DW  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DW  registered read data; valid with dbg_ack and held until the next read.
- dump_start  in  1  pulse that starts a full dump.
- dump_busy  out  1  a dump is pending or in progress.
- dump_valid  out  1  dump_idx/dump_data valid this cycle.
- dump_idx  out  5  register index being dumped.
- dump_data  out  DW  value of register dump_idx.

Behaviour:
- Reset: every output and register goes to 0 and the FSM goes to IDLE. Asynchronous reset mid-operation aborts any access or dump with no ack and clears the dump-pending flag.
- FSM states: IDLE, DBG_RD, DBG_WR, DUMP, ACK.
- cpu_stall = (state is DBG_RD, DBG_WR or DUMP); it is decoded from registered state only.
- Port muxing:
  - In IDLE and ACK: rf_rb = cpu_rb; rf_we/rf_rw/rf_wdata = cpu_we/cpu_rw/cpu_wdata.
  - In stalled states: CPU write suppressed; rf_rb = dbg_addr (DBG_RD) or dump_idx (DUMP).
  - cpu_busB = rf_busB always.
- IDLE transitions:
  - dbg_req=1 goes to DBG_RD or DBG_WR according to dbg_wr.
  - Otherwise, dump_start or dump pending goes to DUMP with dump_idx=0.
  - dbg_req beats dump_start in the same cycle; dump_start is then latched as pending and dump_busy=1.
- DBG_RD: one cycle; dbg_rdata captures rf_busB at the closing edge; go to ACK.
- DBG_WR: one cycle; rf_we = 1 only if dbg_addr != 0 and dbg_addr < REGNUM; go to ACK.
- ACK: dbg_ack=1 for exactly one cycle; dbg_req is ignored this cycle; go to IDLE. CPU runs unstalled.
- Out-of-range dbg_addr (>= REGNUM): the read returns 0 and the write is dropped; ack still follows.
- Writes to register 0 are dropped but acked.
- DUMP:
  - One register per cycle: dump_valid=1, dump_data=rf_busB, dump_idx increments.
  - After dump_idx = REGNUM-1, clear pending and dump_busy, then go to IDLE.
  - A dbg_req during DUMP waits until the dump finishes or pauses.
  - dump_start while busy is ignored.
- Starvation guard:
  - A counter tracks consecutive cpu_stall=1 cycles.
  - When it reaches STARVE_MAX, the next cycle is forced to an IDLE-equivalent CPU slot: stall=0, dump paused with dump_idx retained, dump_valid=0. The counter then clears.
  - A DUMP resumes at the retained dump_idx.
- Latency:
  - Debug access: request sampled at edge N, ack during cycle N+2, so a single access costs 1 stalled cycle.
  - Full dump: REGNUM stalled cycles plus floor((REGNUM-1)/STARVE_MAX) CPU slots.
- The CPU write and the debug write never reach rf_we in the same cycle.

Decomposition:
- Shared package regfile_arb_pkg holds the FSM state enum and the REG0_INDEX constant.
- Natural sub-module: regfile_dump_seq (dump index counter, pending flag, pause/resume), instantiated once.
- Port mux and FSM stay in the top.

Test Plan:
- Debug write then read: dbg write addr 3 data 0xDEADBEEF; then dbg read addr 3 -> each ack one cycle, cpu_stall high for exactly 1 cycle per access, dbg_rdata=0xDEADBEEF.
- Register 0 and out-of-range: dbg write addr 0 data 0x5 -> ack, rf_we=0. Dbg read addr 9 with REGNUM=8 -> dbg_rdata=0.
- CPU write contention: cpu_we=1 rw=2 in the DBG_WR cycle -> CPU write suppressed. Same write repeated in the ACK cycle -> reg 2 updated.
- Dump with STARVE_MAX=4, REGNUM=8: regs preloaded i*0x11 -> dump_valid for idx 0..3, one unstalled cycle, then idx 4..7 with data 0x00..0x77. dump_busy falls after idx 7.
- Simultaneous start: dbg_req and dump_start in the same cycle -> read completes and acks first, then the dump starts at idx 0.
- Reset mid-operation: assert RST during DUMP at idx 5 -> outputs 0 immediately, no dump_valid after release, dump_busy=0.
